// File: rtl/decode_regfile_if.sv
// Writeback-to-decode write port: the writeback stage drives a register
// write that the decode register file commits.
interface decode_regfile_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
);
    logic               RegWriteW;
    logic [A_WIDTH-1:0] RdW;
    logic [D_WIDTH-1:0] ResultW;

    modport master (
        output RegWriteW,
        output RdW,
        output ResultW
    );

    modport slave (
        input RegWriteW,
        input RdW,
        input ResultW
    );
endinterface

// File: rtl/decode_regfile.sv
// Decode-stage integer register file with write-through bypass on both read
// ports, feeding a stallable/flushable Execute pipeline register.
module decode_regfile #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    decode_regfile_if.slave    wb,
    input  logic [A_WIDTH-1:0] A1D,
    input  logic [A_WIDTH-1:0] A2D,
    input  logic               EnE,
    input  logic               FlushE,
    output logic [D_WIDTH-1:0] RD1E,
    output logic [D_WIDTH-1:0] RD2E,
    output logic [A_WIDTH-1:0] Rs1E,
    output logic [A_WIDTH-1:0] Rs2E,
    output logic [D_WIDTH-1:0] a0
);
    localparam int DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH-1:0] A0_IDX = A_WIDTH'(10);

    logic [D_WIDTH-1:0] regs_q [DEPTH];
    logic [D_WIDTH-1:0] regs_d [DEPTH];

    logic [D_WIDTH-1:0] rd1_d, rd1_q;
    logic [D_WIDTH-1:0] rd2_d, rd2_q;
    logic [A_WIDTH-1:0] rs1_d, rs1_q;
    logic [A_WIDTH-1:0] rs2_d, rs2_q;

    logic [D_WIDTH-1:0] rd1_comb;
    logic [D_WIDTH-1:0] rd2_comb;
    logic               wr_en;

    // Writes to x0 are dropped so entry 0 stays hardwired to zero.
    assign wr_en = wb.RegWriteW && (wb.RdW != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wb.RdW] = wb.ResultW;
        end
        regs_d[0] = '0;
    end

    // The in-flight writeback value wins over the stored entry.
    always_comb begin
        rd1_comb = '0;
        if (A1D != '0) begin
            if (wb.RegWriteW && (wb.RdW == A1D)) begin
                rd1_comb = wb.ResultW;
            end else begin
                rd1_comb = regs_q[A1D];
            end
        end

        rd2_comb = '0;
        if (A2D != '0) begin
            if (wb.RegWriteW && (wb.RdW == A2D)) begin
                rd2_comb = wb.ResultW;
            end else begin
                rd2_comb = regs_q[A2D];
            end
        end
    end

    // Flush beats enable; with neither, the Execute register holds.
    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        if (FlushE) begin
            rd1_d = '0;
            rd2_d = '0;
            rs1_d = '0;
            rs2_d = '0;
        end else if (EnE) begin
            rd1_d = rd1_comb;
            rd2_d = rd2_comb;
            rs1_d = A1D;
            rs2_d = A2D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rd1_q <= '0;
            rd2_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            regs_q <= regs_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
        end
    end

    assign RD1E = rd1_q;
    assign RD2E = rd2_q;
    assign Rs1E = rs1_q;
    assign Rs2E = rs2_q;
    assign a0   = regs_q[A0_IDX];
endmodule

// File: tb/tb_decode_regfile.sv
// Directed, table-driven bench for decode_regfile plus hand-written
// sequences for asynchronous reset and a0 timing.
module tb_decode_regfile;
    logic        clk;
    logic        rst_n;
    logic [4:0]  A1D;
    logic [4:0]  A2D;
    logic        EnE;
    logic        FlushE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [31:0] a0;

    int assertCount;
    int failCount;

    decode_regfile_if #(.D_WIDTH(32), .A_WIDTH(5)) wbIf ();

    decode_regfile #(.D_WIDTH(32), .A_WIDTH(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wb     (wbIf),
        .A1D    (A1D),
        .A2D    (A2D),
        .EnE    (EnE),
        .FlushE (FlushE),
        .RD1E   (RD1E),
        .RD2E   (RD2E),
        .Rs1E   (Rs1E),
        .Rs2E   (Rs2E),
        .a0     (a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        en;
        logic        flush;
        logic [31:0] expRd1;
        logic [31:0] expRd2;
        logic [4:0]  expRs1;
        logic [4:0]  expRs2;
        logic [31:0] expA0;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive inputs just after an edge, then advance through the next edge.
    task automatic applyStimulus(input logic we, input logic [4:0] rd,
                                 input logic [31:0] result, input logic [4:0] a1,
                                 input logic [4:0] a2, input logic en,
                                 input logic flush);
        wbIf.RegWriteW = we;
        wbIf.RdW       = rd;
        wbIf.ResultW   = result;
        A1D            = a1;
        A2D            = a2;
        EnE            = en;
        FlushE         = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".RD1E"}, RD1E, 32'h0);
        checkOutput({tag, ".RD2E"}, RD2E, 32'h0);
        checkOutput({tag, ".Rs1E"}, {27'h0, Rs1E}, 32'h0);
        checkOutput({tag, ".Rs2E"}, {27'h0, Rs2E}, 32'h0);
        checkOutput({tag, ".a0"}, a0, 32'h0);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;

        vecs[0]  = '{1'b1, 5'd3,  32'h00000011, 5'd0,  5'd0,  1'b1, 1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  32'h0};
        vecs[1]  = '{1'b1, 5'd4,  32'h00000022, 5'd3,  5'd4,  1'b1, 1'b0, 32'h11,       32'h22,       5'd3,  5'd4,  32'h0};
        vecs[2]  = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd3,  1'b1, 1'b0, 32'h0,        32'h11,       5'd0,  5'd3,  32'h0};
        vecs[3]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  1'b1, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd7,  5'd7,  32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd4,  5'd0,  1'b0, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd7,  5'd7,  32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd4,  5'd0,  1'b0, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd7,  5'd7,  32'h0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd4,  5'd0,  1'b0, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd7,  5'd7,  32'h0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd4,  5'd3,  1'b1, 1'b0, 32'h22,       32'h11,       5'd4,  5'd3,  32'h0};
        vecs[8]  = '{1'b1, 5'd9,  32'h00000099, 5'd3,  5'd4,  1'b1, 1'b1, 32'h0,        32'h0,        5'd0,  5'd0,  32'h0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  1'b1, 1'b0, 32'h99,       32'h0,        5'd9,  5'd0,  32'h0};
        vecs[10] = '{1'b1, 5'd10, 32'h000000FF, 5'd10, 5'd10, 1'b1, 1'b0, 32'hFF,       32'hFF,       5'd10, 5'd10, 32'hFF};
        vecs[11] = '{1'b1, 5'd11, 32'h00001234, 5'd11, 5'd10, 1'b1, 1'b0, 32'h1234,     32'hFF,       5'd11, 5'd10, 32'hFF};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd11, 5'd10, 1'b0, 1'b1, 32'h0,        32'h0,        5'd0,  5'd0,  32'hFF};

        wbIf.RegWriteW = 1'b0;
        wbIf.RdW       = '0;
        wbIf.ResultW   = '0;
        A1D            = '0;
        A2D            = '0;
        EnE            = 1'b0;
        FlushE         = 1'b0;
        rst_n          = 1'b0;

        #12;
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #10;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].we, vecs[i].rd, vecs[i].result, vecs[i].a1,
                          vecs[i].a2, vecs[i].en, vecs[i].flush);
            checkOutput($sformatf("vec%0d.RD1E", i), RD1E, vecs[i].expRd1);
            checkOutput($sformatf("vec%0d.RD2E", i), RD2E, vecs[i].expRd2);
            checkOutput($sformatf("vec%0d.Rs1E", i), {27'h0, Rs1E}, {27'h0, vecs[i].expRs1});
            checkOutput($sformatf("vec%0d.Rs2E", i), {27'h0, Rs2E}, {27'h0, vecs[i].expRs2});
            checkOutput($sformatf("vec%0d.a0", i), a0, vecs[i].expA0);
        end

        // a0 must not see the pending write before the edge.
        wbIf.RegWriteW = 1'b1;
        wbIf.RdW       = 5'd10;
        wbIf.ResultW   = 32'h00000077;
        EnE            = 1'b0;
        FlushE         = 1'b0;
        #2;
        checkOutput("a0.beforeEdge", a0, 32'hFF);
        @(posedge clk);
        #1;
        checkOutput("a0.afterEdge", a0, 32'h77);

        // Load x5 and capture it, then reset mid-cycle.
        applyStimulus(1'b1, 5'd5, 32'h00001234, 5'd5, 5'd10, 1'b1, 1'b0);
        checkOutput("preReset.RD1E", RD1E, 32'h1234);
        checkOutput("preReset.RD2E", RD2E, 32'h77);
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd10, 1'b0, 1'b0);
        checkOutput("preReset.hold", RD1E, 32'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("asyncReset");

        // Edges during reset must not commit writes.
        wbIf.RegWriteW = 1'b1;
        wbIf.RdW       = 5'd10;
        wbIf.ResultW   = 32'hCAFEF00D;
        EnE            = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("inReset.a0", a0, 32'h0);
        checkOutput("inReset.RD1E", RD1E, 32'h0);
        rst_n = 1'b1;

        applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd10, 1'b1, 1'b0);
        checkOutput("postReset.RD1E", RD1E, 32'h0);
        checkOutput("postReset.RD2E", RD2E, 32'h0);
        checkOutput("postReset.Rs1E", {27'h0, Rs1E}, 32'd5);
        checkOutput("postReset.a0", a0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/decode_regfile.md
# decode_regfile

Decode-side consumer of the writeback interface. Holds the 32 × D_WIDTH integer register file and accepts the write port (RegWriteW, RdW, ResultW) that the writeback stage drives. It serves two combinational read ports with same-cycle write-through bypass. The read results and source addresses are registered into the Execute stage, with stall-hold and flush-to-bubble control.

## Interface
Parameters:
- D_WIDTH, 32, data width of each register
- A_WIDTH, 5, register address width; array depth is 2**A_WIDTH

Ports:
- clk  in  1  rising-edge clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- RegWriteW  in  1  write enable from writeback
- RdW  in  A_WIDTH  write address from writeback
- ResultW  in  D_WIDTH  write data from writeback
- A1D  in  A_WIDTH  Decode-stage read address 1 (rs1)
- A2D  in  A_WIDTH  Decode-stage read address 2 (rs2)
- EnE  in  1  Execute register enable; 0 = hold (stall)
- FlushE  in  1  Execute register flush; 1 = load bubble
- RD1E  out  D_WIDTH  registered read data 1
- RD2E  out  D_WIDTH  registered read data 2
- Rs1E  out  A_WIDTH  registered A1D, for the forwarding unit
- Rs2E  out  A_WIDTH  registered A2D, for the forwarding unit
- a0  out  D_WIDTH  live content of register x10

## Operation
- Array: 2**A_WIDTH entries of D_WIDTH bits. Entry 0 is hardwired to zero.
- Write: on the rising clk edge, if RegWriteW=1 and RdW≠0, then reg[RdW] ← ResultW. A write with RdW=0 is discarded.
- Combinational read, port n:
  - if AnD=0, result is 0
  - else if RegWriteW=1 and RdW=AnD, result is ResultW (bypass)
  - else result is reg[AnD]
- Execute register update on the rising edge, in priority order:
  1. FlushE=1: RD1E, RD2E, Rs1E and Rs2E all ← 0, regardless of EnE.
  2. else EnE=1: capture both read results, A1D and A2D.
  3. else: hold all four outputs.
- FlushE and EnE do not affect array writes. Writeback always commits.
- a0 = reg[10], taken directly from the array. There is no bypass on a0.
- There are no arithmetic operations. All data paths are D_WIDTH with no extension.

## Timing
- Reset (rst_n=0, asynchronous): every array entry, RD1E, RD2E, Rs1E, Rs2E and a0 go to 0 immediately, without waiting for a clock edge. Rising edges are ignored while rst_n=0.
- Reset deassertion takes effect at the first rising edge after rst_n goes high.
- Write-to-read latency:
  - The bypass makes a write visible on the combinational read in the same cycle.
  - RD1E/RD2E reflect it at the next edge.
- A1D→RD1E and A2D→RD2E latency is 1 cycle when EnE=1.
- a0 changes in the cycle after the write edge.
- Simultaneous write and read of the same register: the read returns the new value ResultW.
- A1D=A2D with bypass active: both ports return ResultW.
- Reset mid-stall: the held values are lost and all outputs read 0.

## Test plan
- Reset: load x5=0x1234, then pulse rst_n low mid-cycle → a0, RD1E, RD2E, Rs1E, Rs2E = 0 without a clock edge; a subsequent read of x5 gives 0.
- x0 protection: RegWriteW=1, RdW=0, ResultW=0xDEADBEEF; next cycle A1D=0, EnE=1 → RD1E=0 one edge later.
- Bypass: in the same cycle RegWriteW=1, RdW=7, ResultW=0xA5A5A5A5, A1D=7, A2D=7, EnE=1 → after the edge RD1E=RD2E=0xA5A5A5A5, Rs1E=Rs2E=7.
- Stall: x3=0x11, A1D=3, EnE=1, edge → RD1E=0x11. Then EnE=0, A1D=4 with x4=0x22 for 3 cycles → RD1E stays 0x11. Then EnE=1 → RD1E=0x22.
- Flush priority: FlushE=1 and EnE=1 with A1D=3 → RD1E=0, Rs1E=0. A write to x9 in the same cycle still commits; a later read of x9 returns the written value.
- a0 tracking: write x10=0x000000FF → a0 is 0 before the edge and 0xFF from the cycle after. Writes to x11 leave a0 unchanged.
